// File: rtl/par2ser_pkg.sv
// Shared types and helpers for the parallel-to-serial fifo loader.
// The PARITY state is only reached when the design is built with PARITY_EN.
package par2ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } ldr_state_t;

    // Bit count needed to hold WIDTH remaining bits plus headroom.
    function automatic int cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/par2ser_loader_if.sv
// Handshake and fifo write-side bundle for par2ser_loader.
// master = the loader itself, slave = the environment (producer + fifo).
interface par2ser_loader_if
    import par2ser_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] par_data;
    logic             par_valid;
    logic             par_ready;
    logic             flush;
    logic             fifo_full;
    logic             fifo_insert;
    logic             fifo_data;
    logic             busy;
    logic             word_done;

    modport master (
        input  par_data, par_valid, flush, fifo_full,
        output par_ready, fifo_insert, fifo_data, busy, word_done
    );

    modport slave (
        output par_data, par_valid, flush, fifo_full,
        input  par_ready, fifo_insert, fifo_data, busy, word_done
    );
endinterface

// File: rtl/par2ser_loader.sv
// Serialises parallel words one bit per clk_in into a 1-bit fifo, honouring fifo_full.
// Build option: define PARITY_EN to append an even-parity bit after each word.
module par2ser_loader
    import par2ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk_in,
    input  logic                    rst,
    par2ser_loader_if.master        bus
);

    localparam int CW = cnt_w(WIDTH);

    ldr_state_t       state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [CW-1:0]    count_reg;
    logic             word_done_reg;
`ifdef PARITY_EN
    logic             parity_reg;
`endif

    logic [WIDTH-1:0] load_word;
    logic             inserting;
    logic             last_ins;
    logic             accept;

    // The shifter always emits from the top, so LSB-first words are bit-reversed on load.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
        assign load_word[gi] = MSB_FIRST ? bus.par_data[gi] : bus.par_data[WIDTH-1-gi];
    end

    assign bus.busy        = (state_reg != IDLE);
    assign inserting       = !rst && bus.busy && !bus.fifo_full;
    assign bus.fifo_insert = inserting;
    assign bus.word_done   = word_done_reg;

`ifdef PARITY_EN
    assign last_ins      = inserting && (state_reg == PAR);
    assign bus.fifo_data = (state_reg == PAR) ? parity_reg : shreg_reg[WIDTH-1];
`else
    assign last_ins      = inserting && (state_reg == SHIFT) && (count_reg == CW'(1));
    assign bus.fifo_data = shreg_reg[WIDTH-1];
`endif

    assign bus.par_ready = !rst && ((state_reg == IDLE) || last_ins);
    assign accept        = bus.par_valid && bus.par_ready && !bus.flush;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            count_reg     <= '0;
            word_done_reg <= 1'b0;
`ifdef PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else if (bus.flush) begin
            // Clearing the shifter keeps fifo_data at 0 while idle.
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            count_reg     <= '0;
            word_done_reg <= 1'b0;
        end else begin
            word_done_reg <= last_ins;
            if (accept) begin
                state_reg <= SHIFT;
                shreg_reg <= load_word;
                count_reg <= CW'(WIDTH);
`ifdef PARITY_EN
                parity_reg <= ^bus.par_data;
`endif
            end else if (inserting) begin
                case (state_reg)
                    SHIFT: begin
                        shreg_reg <= {shreg_reg[WIDTH-2:0], 1'b0};
                        count_reg <= count_reg - CW'(1);
                        if (count_reg == CW'(1)) begin
`ifdef PARITY_EN
                            state_reg <= PAR;
`else
                            state_reg <= IDLE;
`endif
                        end
                    end
                    PAR:     state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_par2ser_loader.sv
// Bench for par2ser_loader: MSB-first and LSB-first instances share stimulus,
// a queue-based word model checks every cycle, plus directed vectors and corner sequences.
module tb_par2ser_loader;

    localparam int WIDTH = 8;
`ifdef PARITY_EN
    localparam int WL = WIDTH + 1;
`else
    localparam int WL = WIDTH;
`endif

    logic             clk_in = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] par_data = '0;
    logic             par_valid = 1'b0;
    logic             flush = 1'b0;
    logic             fifo_full = 1'b0;

    always #5 clk_in = ~clk_in;

    par2ser_loader_if #(.WIDTH(WIDTH)) if_m ();
    par2ser_loader_if #(.WIDTH(WIDTH)) if_l ();

    assign if_m.par_data  = par_data;
    assign if_m.par_valid = par_valid;
    assign if_m.flush     = flush;
    assign if_m.fifo_full = fifo_full;
    assign if_l.par_data  = par_data;
    assign if_l.par_valid = par_valid;
    assign if_l.flush     = flush;
    assign if_l.fifo_full = fifo_full;

    par2ser_loader #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
        .clk_in(clk_in), .rst(rst), .bus(if_m)
    );
    par2ser_loader #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
        .clk_in(clk_in), .rst(rst), .bus(if_l)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted word becomes a queue of pending bits.
    bit   q_m[$];
    bit   q_l[$];
    logic wd_exp = 1'b0;
    int   mn;
    logic exp_ins, exp_rdy, exp_busy;

    always @(negedge clk_in) begin
        mn       = q_m.size();
        exp_busy = (mn > 0);
        exp_ins  = !rst && exp_busy && !fifo_full;
        exp_rdy  = !rst && (mn == 0 || (mn == 1 && !fifo_full));
        check("insert_m", 32'(if_m.fifo_insert), 32'(exp_ins));
        check("insert_l", 32'(if_l.fifo_insert), 32'(exp_ins));
        check("ready_m",  32'(if_m.par_ready),   32'(exp_rdy));
        check("ready_l",  32'(if_l.par_ready),   32'(exp_rdy));
        check("busy_m",   32'(if_m.busy),        32'(exp_busy));
        check("busy_l",   32'(if_l.busy),        32'(exp_busy));
        check("done_m",   32'(if_m.word_done),   32'(wd_exp));
        check("done_l",   32'(if_l.word_done),   32'(wd_exp));
        check("data_m",   32'(if_m.fifo_data),   32'(exp_busy ? q_m[0] : 1'b0));
        check("data_l",   32'(if_l.fifo_data),   32'(exp_busy ? q_l[0] : 1'b0));
        if (rst || flush) begin
            q_m.delete();
            q_l.delete();
            wd_exp = 1'b0;
        end else begin
            wd_exp = exp_ins && (mn == 1);
            if (exp_ins) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
            end
            if (par_valid && exp_rdy) begin
                for (int i = 0; i < WIDTH; i++) begin
                    q_m.push_back(par_data[WIDTH-1-i]);
                    q_l.push_back(par_data[i]);
                end
`ifdef PARITY_EN
                q_m.push_back(^par_data);
                q_l.push_back(^par_data);
`endif
            end
        end
    end

    typedef struct {
        logic [7:0]  data;
        logic [31:0] full_mask;   // bit c: fifo_full during cycle c after accept
        int          flush_at;    // cycle index carrying flush, 0 = none
        int          exp_n;
        logic [15:0] exp_m;
        logic [15:0] exp_l;
        int          exp_done;    // cycle word_done is seen, 0 = never
    } vec_t;

    vec_t vecs[7];

    task automatic wait_idle();
        int k;
        for (k = 0; k < 60; k++) begin
            if (!if_m.busy && !rst) break;
            @(posedge clk_in); #1;
        end
        if (k == 60) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n, done;
        logic [15:0] sm, sl;
        wait_idle();
        par_data  = v.data;
        par_valid = 1'b1;
        @(posedge clk_in); #1;
        par_valid = 1'b0;
        n = 0; done = 0; sm = '0; sl = '0;
        for (int c = 1; c <= 20; c++) begin
            fifo_full = v.full_mask[c];
            flush     = (c == v.flush_at);
            @(negedge clk_in);
            if (if_m.fifo_insert && !flush) begin
                sm = {sm[14:0], if_m.fifo_data};
                sl = {sl[14:0], if_l.fifo_data};
                n++;
            end
            if (if_m.word_done && done == 0) done = c;
            @(posedge clk_in); #1;
        end
        fifo_full = 1'b0;
        flush     = 1'b0;
        check($sformatf("vec%0d_count", idx),  32'(n),    32'(v.exp_n));
        check($sformatf("vec%0d_msb", idx),    32'(sm),   32'(v.exp_m));
        check($sformatf("vec%0d_lsb", idx),    32'(sl),   32'(v.exp_l));
        check($sformatf("vec%0d_done", idx),   32'(done), 32'(v.exp_done));
    endtask

    initial begin
        int d1, d2;
        logic [31:0] ins_mask, exp_mask;
        logic acc_now;

`ifdef PARITY_EN
        vecs[0] = '{8'hA5, 32'h0,  0, 9, 16'h14A, 16'h14A, 10};
        vecs[1] = '{8'hA5, 32'h38, 0, 9, 16'h14A, 16'h14A, 13};
        vecs[2] = '{8'h3C, 32'h0,  0, 9, 16'h078, 16'h078, 10};
        vecs[3] = '{8'hC6, 32'h0,  4, 3, 16'h006, 16'h003, 0};
        vecs[4] = '{8'hFF, 32'h0,  0, 9, 16'h1FE, 16'h1FE, 10};
        vecs[5] = '{8'h01, 32'h0,  0, 9, 16'h003, 16'h101, 10};
        vecs[6] = '{8'h07, 32'h0,  0, 9, 16'h00F, 16'h1C1, 10};
`else
        vecs[0] = '{8'hA5, 32'h0,  0, 8, 16'hA5, 16'hA5, 9};
        vecs[1] = '{8'hA5, 32'h38, 0, 8, 16'hA5, 16'hA5, 12};
        vecs[2] = '{8'h3C, 32'h0,  0, 8, 16'h3C, 16'h3C, 9};
        vecs[3] = '{8'hC6, 32'h0,  4, 3, 16'h06, 16'h03, 0};
        vecs[4] = '{8'hFF, 32'h0,  0, 8, 16'hFF, 16'hFF, 9};
        vecs[5] = '{8'h01, 32'h0,  0, 8, 16'h01, 16'h80, 9};
        vecs[6] = '{8'h07, 32'h0,  0, 8, 16'h07, 16'hE0, 9};
`endif

        // Reset state, sampled while rst is still high.
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check("rst_busy",   32'(if_m.busy),        32'd0);
        check("rst_ready",  32'(if_m.par_ready),   32'd0);
        check("rst_insert", 32'(if_m.fifo_insert), 32'd0);
        check("rst_done",   32'(if_m.word_done),   32'd0);
        check("rst_data",   32'(if_m.fifo_data),   32'd0);
        @(posedge clk_in); #1;
        rst = 1'b0;
        @(negedge clk_in);
        check("post_rst_ready", 32'(if_m.par_ready), 32'd1);
        @(posedge clk_in); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Back-to-back: A5 then 3C with par_valid held.
        wait_idle();
        par_data = 8'hA5; par_valid = 1'b1;
        @(posedge clk_in); #1;
        par_data = 8'h3C;
        ins_mask = '0; d1 = 0; d2 = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk_in);
            if (if_m.fifo_insert) ins_mask[c] = 1'b1;
            if (if_m.word_done) begin
                if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
            end
            acc_now = if_m.par_ready && par_valid;
            @(posedge clk_in); #1;
            if (acc_now) par_valid = 1'b0;
        end
        exp_mask = '0;
        for (int c = 1; c <= 2 * WL; c++) exp_mask[c] = 1'b1;
        check("b2b_inserts", ins_mask, exp_mask);
        check("b2b_done1",   32'(d1),      32'(WL + 1));
        check("b2b_gap",     32'(d2 - d1), 32'(WL));

        // Reset in the middle of a word.
        wait_idle();
        par_data = 8'h5A; par_valid = 1'b1;
        @(posedge clk_in); #1;
        par_valid = 1'b0;
        repeat (3) begin @(posedge clk_in); #1; end
        rst = 1'b1;
        @(negedge clk_in);
        check("midrst_ready",  32'(if_m.par_ready),   32'd0);
        check("midrst_insert", 32'(if_m.fifo_insert), 32'd0);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check("midrst_busy", 32'(if_m.busy),      32'd0);
        check("midrst_done", 32'(if_m.word_done), 32'd0);
        check("midrst_data", 32'(if_l.fifo_data), 32'd0);
        @(posedge clk_in); #1;
        rst = 1'b0;
        @(negedge clk_in);
        check("midrst_release_ready", 32'(if_m.par_ready), 32'd1);
        @(posedge clk_in); #1;

        // Randomised traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            par_valid = ($urandom_range(0, 3) != 0);
            par_data  = 8'($urandom);
            fifo_full = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            @(posedge clk_in); #1;
        end
        par_valid = 1'b0; fifo_full = 1'b0; flush = 1'b0; rst = 1'b0;
        repeat (2 * WL + 4) begin @(posedge clk_in); #1; end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
